dot_product_acc: RTL

DOT_PRODUCT_ACC -- requirements
Module: dot_product_acc

---
 rtl/dot_product_acc_pkg.sv | 24 ++
 rtl/wallace_tree_unsigned.sv | 30 +++
 rtl/dot_product_acc.sv | 91 +++++++++
 3 files changed

// File: rtl/dot_product_acc_pkg.sv
// Shared definitions for the dot-product accumulator: FSM states, widths and
// the carry-save compressor used by the Wallace tree multiplier.
package dot_product_acc_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int CNT_W     = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  // 3:2 compressor across 16 columns; returns {carry, sum}
  function automatic logic [31:0] csa(input logic [15:0] x, input logic [15:0] y,
                                      input logic [15:0] z);
    logic [15:0] s, c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

endpackage

// File: rtl/wallace_tree_unsigned.sv
// 8x8 unsigned multiplier: partial products reduced 8->6->4->3->2 rows by
// carry-save layers, then one carry-propagate add.
module wallace_tree_unsigned
  import dot_product_acc_pkg::*;
(
  input  logic [7:0]  a_i,
  input  logic [7:0]  b_i,
  output logic [15:0] p_o
);

  logic [15:0] pp [8];
  logic [31:0] l1a, l1b, l2a, l2b, l3a, l4a;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = {8'd0, a_i & {8{b_i[i]}}} << i;
    end
  end

  assign l1a = csa(pp[0], pp[1], pp[2]);
  assign l1b = csa(pp[3], pp[4], pp[5]);
  assign l2a = csa(l1a[15:0], l1a[31:16], l1b[15:0]);
  assign l2b = csa(l1b[31:16], pp[6], pp[7]);
  assign l3a = csa(l2a[15:0], l2a[31:16], l2b[15:0]);
  assign l4a = csa(l3a[15:0], l3a[31:16], l2b[31:16]);

  // Carries out of bit 15 are dropped; an 8x8 product always fits 16 bits.
  assign p_o = l4a[15:0] + l4a[31:16];

endmodule

// File: rtl/dot_product_acc.sv
// Streaming unsigned dot product: multiplies accepted (a,b) pairs into a
// product register and accumulates them, presenting the sum after the run.
module dot_product_acc
  import dot_product_acc_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] result,
  output logic             busy
);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q, len_q;
  logic [15:0]      p_q, prod;
  logic             p_vld_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             in_ready_q, out_valid_q, busy_q;
  logic             accept, last;

  wallace_tree_unsigned u_mul (
    .a_i (a),
    .b_i (b),
    .p_o (prod)
  );

  assign accept = in_valid && in_ready_q;
  assign last   = (cnt_q + CNT_W'(1)) == len_q;
  assign acc_d  = acc_q + ACC_W'(p_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      p_q         <= '0;
      p_vld_q     <= 1'b0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      p_vld_q <= accept;
      if (accept) p_q <= prod;
      if (p_vld_q) acc_q <= acc_d;
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_RUN;
          acc_q      <= '0;
          cnt_q      <= '0;
          // len of 0 means a full 256-pair vector
          len_q      <= {len == 8'd0, len};
          in_ready_q <= 1'b1;
          busy_q     <= 1'b1;
        end
        S_RUN: if (accept) begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) begin
            state_q    <= S_DRAIN;
            in_ready_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          state_q     <= S_DONE;
          out_valid_q <= 1'b1;
        end
        S_DONE: if (out_ready) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign result    = out_valid_q ? acc_q : '0;

endmodule
